// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline constants: payload widths, control sub-field offsets,
// and the skid-buffer occupancy states.
package pipe_pkg;

    localparam int ID_EX_CTRL_W = 16;
    localparam int ID_EX_DATA_W = 96;

    // Bit positions of the control sub-fields inside the ID/EX control word
    localparam int CTRL_JUMP_BIT     = 0;
    localparam int CTRL_BRANCH_BIT   = 1;
    localparam int CTRL_REGWRITE_BIT = 2;
    localparam int CTRL_MEM_LSB      = 3;
    localparam int CTRL_MEM_W        = 3;
    localparam int CTRL_ALUOP_LSB    = 6;
    localparam int CTRL_ALUOP_W      = 4;
    localparam int CTRL_ALUSRC_BIT   = 10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag, control word and data word.
// Clear drops valid and control but keeps data to avoid needless toggling.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // NOTE: nonblocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload is reset too, so a freshly reset stage presents all zeros.
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_ctrl  <= d_ctrl;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EX pipeline stage with valid/ready handshake and flush. SKID=1 uses a
// 2-entry skid buffer with registered in_ready; SKID=0 a single register.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_ctrl  (main_ctrl_d),
        .d_data  (main_data_d),
        .q_valid (out_valid),
        .q_ctrl  (out_ctrl),
        .q_data  (out_data)
    );

    if (SKID != 0) begin : g_skid
        skid_state_e       state_q, state_d;
        logic              in_ready_q;
        logic              skid_load, skid_clear, skid_valid;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load),
            .clear   (skid_clear),
            .d_ctrl  (in_ctrl),
            .d_data  (in_data),
            .q_valid (skid_valid),
            .q_ctrl  (skid_ctrl),
            .q_data  (skid_data)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_EMPTY;
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                in_ready_q <= (state_d != ST_FULL);
            end
        end

        always_comb begin
            // NOTE: every output gets a default first, so no path can infer a latch.
            state_d     = state_q;
            main_load   = 1'b0;
            main_clear  = 1'b0;
            skid_load   = 1'b0;
            skid_clear  = 1'b0;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            if (flush) begin
                state_d    = ST_EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer) begin
                            main_load = 1'b1;
                            state_d   = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_load = 1'b1;
                        end else if (in_xfer) begin
                            skid_load = 1'b1;
                            state_d   = ST_FULL;
                        end else if (out_xfer) begin
                            main_clear = 1'b1;
                            state_d    = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // Oldest-first: the skid word advances into MAIN
                        if (out_xfer) begin
                            main_load   = 1'b1;
                            main_ctrl_d = skid_ctrl;
                            main_data_d = skid_data;
                            skid_clear  = 1'b1;
                            state_d     = ST_ONE;
                        end
                    end
                    default: begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                        skid_clear = 1'b1;
                    end
                endcase
            end
        end

        assign in_ready = in_ready_q;
        assign occ      = {out_valid & skid_valid, out_valid ^ skid_valid};
    end else begin : g_single
        assign in_ready = !out_valid || out_ready;
        assign occ      = {1'b0, out_valid};

        always_comb begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_load   = in_xfer;
            main_clear  = flush || (out_xfer && !in_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus; a
// queue scoreboard checks order/data on output transfers, plus directed checks.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 96;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_ready;

    logic              in_ready_w  [2];
    logic              out_valid_w [2];
    logic [CTRL_W-1:0] out_ctrl_w  [2];
    logic [DATA_W-1:0] out_data_w  [2];
    logic [1:0]        occ_w       [2];

    item_t exp_q [2][$];
    int    n_out [2];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[1]), .out_data(out_data_w[1]), .occ(occ_w[1])
    );

    pipe_stage_skid #(.SKID(0)) dut_single (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[0]), .out_data(out_data_w[0]), .occ(occ_w[0])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control word is derived from the data so each word carries a distinct tag
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = {d[7:0], ~d[7:0]};
        flush     = f;
        out_ready = r;
    endtask

    // Scoreboard: sampled mid-cycle, describes the transfers of the coming edge
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) exp_q[d].delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_w[d] && out_ready) begin
                    n_out[d]++;
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb%0d_extra: got data 0x%0h, expected no output word", d, out_data_w[d]);
                    end else begin
                        item_t e;
                        e = exp_q[d].pop_front();
                        check($sformatf("sb%0d_data", d), 128'(out_data_w[d]), 128'(e.data));
                        check($sformatf("sb%0d_ctrl", d), 128'(out_ctrl_w[d]), 128'(e.ctrl));
                    end
                end
                if (!out_valid_w[d])
                    check($sformatf("sb%0d_ctrl_idle", d), 128'(out_ctrl_w[d]), 128'(0));
                if (flush)
                    exp_q[d].delete();
                else if (in_valid && in_ready_w[d])
                    exp_q[d].push_back('{ctrl: in_ctrl, data: in_data});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    initial begin
        int base [2];
        n_out[0] = 0;
        n_out[1] = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        // Reset state
        check("rst_out_valid", 128'(out_valid_w[1]), 128'(0));
        check("rst_out_ctrl",  128'(out_ctrl_w[1]),  128'(0));
        check("rst_out_data",  128'(out_data_w[1]),  128'(0));
        check("rst_occ",       128'(occ_w[1]),       128'(0));
        check("rst_in_ready1", 128'(in_ready_w[1]),  128'(0));
        check("rst_in_ready0", 128'(in_ready_w[0]),  128'(1));
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready1", 128'(in_ready_w[1]), 128'(1));

        // Single word, one-cycle latency, then drain with data hold
        drive(1'b1, 96'hA5, 1'b0, 1'b1);
        tick();
        drive(1'b0, 96'hA5, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_valid", d), 128'(out_valid_w[d]), 128'(1));
            check($sformatf("lat%0d_data", d),  128'(out_data_w[d]),  128'(96'hA5));
            check($sformatf("lat%0d_ctrl", d),  128'(out_ctrl_w[d]),  128'(16'hA55A));
            check($sformatf("lat%0d_occ", d),   128'(occ_w[d]),       128'(1));
        end
        tick();
        check("drain_valid", 128'(out_valid_w[1]), 128'(0));
        check("drain_ctrl",  128'(out_ctrl_w[1]),  128'(0));
        check("drain_hold",  128'(out_data_w[1]),  128'(96'hA5));
        check("drain_occ",   128'(occ_w[1]),       128'(0));

        // Backpressure fills the skid buffer, then release
        drive(1'b1, 96'h1, 1'b0, 1'b0);
        tick();
        check("bp_occ1",   128'(occ_w[1]),      128'(1));
        check("bp_rdy1",   128'(in_ready_w[1]), 128'(1));
        drive(1'b1, 96'h2, 1'b0, 1'b0);
        tick();
        check("bp_occ2",   128'(occ_w[1]),      128'(2));
        check("bp_rdy2",   128'(in_ready_w[1]), 128'(0));
        check("bp_data2",  128'(out_data_w[1]), 128'(1));
        drive(1'b1, 96'h3, 1'b0, 1'b0);
        tick();
        check("stall_occ",  128'(occ_w[1]),      128'(2));
        check("stall_data", 128'(out_data_w[1]), 128'(1));
        check("stall_rdy",  128'(in_ready_w[1]), 128'(0));
        drive(1'b1, 96'h3, 1'b0, 1'b1);
        tick();
        check("rel_data2", 128'(out_data_w[1]), 128'(2));
        check("rel_occ2",  128'(occ_w[1]),      128'(1));
        check("rel_rdy",   128'(in_ready_w[1]), 128'(1));
        tick();
        check("rel_data3", 128'(out_data_w[1]), 128'(3));
        check("rel_occ3",  128'(occ_w[1]),      128'(1));
        drive(1'b0, 96'h3, 1'b0, 1'b1);
        tick();
        check("rel_empty", 128'(out_valid_w[1]), 128'(0));
        check("rel_occ0",  128'(occ_w[1]),       128'(0));

        // Full throughput for 20 words
        tick();
        base[0] = n_out[0];
        base[1] = n_out[1];
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DATA_W'(100 + i), 1'b0, 1'b1);
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("thr%0d_valid_%0d", d, i), 128'(out_valid_w[d]), 128'(1));
                check($sformatf("thr%0d_data_%0d", d, i),  128'(out_data_w[d]),  128'(100 + i));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("thr%0d_count", d), 128'(n_out[d] - base[d]), 128'(20));

        // Flush while FULL with a word offered
        drive(1'b1, 96'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 96'h22, 1'b0, 1'b0);
        tick();
        check("fl_full_occ", 128'(occ_w[1]), 128'(2));
        drive(1'b1, 96'h33, 1'b1, 1'b0);
        tick();
        check("fl_valid", 128'(out_valid_w[1]), 128'(0));
        check("fl_ctrl",  128'(out_ctrl_w[1]),  128'(0));
        check("fl_occ",   128'(occ_w[1]),       128'(0));
        check("fl_rdy",   128'(in_ready_w[1]),  128'(1));
        check("fl0_occ",  128'(occ_w[0]),       128'(0));
        // Flush in ONE with an acceptable word offered on the same edge
        drive(1'b1, 96'h44, 1'b0, 1'b0);
        tick();
        drive(1'b1, 96'h55, 1'b1, 1'b0);
        tick();
        check("fl1_occ", 128'(occ_w[1]), 128'(0));
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("fl%0d_never_seen", d), 128'(out_valid_w[d]), 128'(0));

        // Asynchronous reset between edges while FULL
        drive(1'b1, 96'h66, 1'b0, 1'b0);
        tick();
        drive(1'b1, 96'h77, 1'b0, 1'b0);
        tick();
        check("ar_full_occ", 128'(occ_w[1]), 128'(2));
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", 128'(out_valid_w[1]), 128'(0));
        check("ar_ctrl",  128'(out_ctrl_w[1]),  128'(0));
        check("ar_occ",   128'(occ_w[1]),       128'(0));
        check("ar0_valid", 128'(out_valid_w[0]), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("ar_rdy_after", 128'(in_ready_w[1]), 128'(1));

        // Random stall/flush traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()},
                  $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (4) tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("sb%0d_leftover", d), 128'(exp_q[d].size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
